// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// Build option DMEM_ARB_RR_EN selects round-robin tie-break.
package dmem_arb_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } arb_state_t;

  typedef logic port_id_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner select for an IDLE arbiter.
// DMEM_ARB_RR_EN: ties go to port != last; else port 0 wins.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic     req0,
  input  logic     req1,
  input  port_id_t last,
  output logic     any,
  output port_id_t win
);

  assign any = req0 | req1;

`ifdef DMEM_ARB_RR_EN
  always_comb begin
    win = port_id_t'(~req0);
    if (req0 & req1)
      win = ~last;
  end
`else
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    win = port_id_t'(~req0);
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port req/gnt arbiter in front of datamem with burst locking.
// Tie-break policy set by DMEM_ARB_RR_EN (see dmem_arb_pick).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic          wr0,
  input  logic          wr1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW =
    (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  arb_state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  port_id_t last, last_nx;
  logic rtag0, rtag1;
  logic pick_any;
  port_id_t pick_win;
  logic burst_ok;

  dmem_arb_pick u_pick (
    .req0 (req0),
    .req1 (req1),
    .last (last),
    .any  (pick_any),
    .win  (pick_win)
  );

  assign burst_ok = int'(cnt) < (MAX_BURST - 1);

  always_comb begin
    gnt0      = (state == OWN0) & req0;
    gnt1      = (state == OWN1) & req1;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    if (gnt0) begin
      mem_addr  = addr0;
      mem_wdata = wdata0;
      mem_rd    = ~wr0;
      mem_wr    = wr0;
    end else if (gnt1) begin
      mem_addr  = addr1;
      mem_wdata = wdata1;
      mem_rd    = ~wr1;
      mem_wr    = wr1;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    last_nx  = last;
    case (state)
      IDLE: begin
        if (pick_any)
          state_nx = pick_win ? OWN1 : OWN0;
      end
      OWN0: begin
        if (req0 & lock0 & burst_ok) begin
          cnt_nx = cnt + CW'(1);
        end else if (req1) begin
          state_nx = OWN1;
          last_nx  = 1'b0;
        end else if (!req0) begin
          state_nx = IDLE;
          last_nx  = 1'b0;
        end
      end
      OWN1: begin
        if (req1 & lock1 & burst_ok) begin
          cnt_nx = cnt + CW'(1);
        end else if (req0) begin
          state_nx = OWN0;
          last_nx  = 1'b1;
        end else if (!req1) begin
          state_nx = IDLE;
          last_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
      rtag0 <= 1'b0;
      rtag1 <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      last  <= last_nx;
      rtag0 <= gnt0 & ~wr0;
      rtag1 <= gnt1 & ~wr1;
    end
  end

  assign rvalid0 = rtag0;
  assign rvalid1 = rtag1;
  assign rdata   = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a datamem model.
// Expected grant/read order adapts to DMEM_ARB_RR_EN.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, lock0, lock1, wr0, wr1;
  logic [7:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata;
  logic [7:0]  mem_addr;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_wdata, mem_rdata;

  logic [15:0] mem [256];
  logic [25:0] gq [$];
  logic [16:0] rq [$];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(8), .DW(16), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .lock0(lock0), .lock1(lock1),
    .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata),
    .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // datamem model: one-cycle registered read, preloaded in reset
  always @(posedge clk) begin
    if (!rst) begin
      mem[8'h10] <= 16'h1234;
      mem[8'h30] <= 16'h0A0A;
      mem[8'h22] <= 16'h0000;
      mem_rdata  <= 16'h0000;
    end else begin
      if (mem_wr) mem[mem_addr] <= mem_wdata;
      if (mem_rd) mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // monitor: pops expectations whenever the DUT presents a grant or rvalid
  always @(negedge clk) begin
    logic [25:0] g;
    logic [16:0] r;
    if (rst) begin
      if (gnt0 | gnt1) begin
        if (gq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL grant_extra: got gnt port %0d required none",
                   gnt1);
        end else begin
          g = gq.pop_front();
          chk("grant", 32'({gnt1, mem_wr, mem_addr, mem_wdata}),
              32'(g));
          chk("grant_rd_excl", 32'({gnt0 & gnt1, mem_rd}),
              32'({1'b0, ~g[24]}));
        end
      end else begin
        chk("idle_strobe", 32'({mem_rd, mem_wr}), 32'd0);
      end
      if (rvalid0 | rvalid1) begin
        if (rq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL rvalid_extra: got rvalid port %0d required none",
                   rvalid1);
        end else begin
          r = rq.pop_front();
          chk("read", 32'({rvalid0 & rvalid1, rvalid1, rdata}),
              32'({1'b0, r}));
        end
      end
    end
  end

  task automatic drive(input bit p, input logic wr,
                       input logic [7:0] a, input logic [15:0] d);
    if (p) begin
      req1 = 1'b1; wr1 = wr; addr1 = a; wdata1 = d;
    end else begin
      req0 = 1'b1; wr0 = wr; addr0 = a; wdata0 = d;
    end
  endtask

  task automatic drop(input bit p);
    if (p) req1 = 1'b0;
    else   req0 = 1'b0;
  endtask

  task automatic wait_gnt(input bit p, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = p ? gnt1 : gnt0;
    end
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL gnt_timeout: port %0d got no gnt in %0d cycles, required gnt",
               p, n);
    end
  endtask

  task automatic access(input bit p, input logic wr,
                        input logic [7:0] a, input logic [15:0] d,
                        output int lat);
    @(posedge clk) #1;
    drive(p, wr, a, d);
    wait_gnt(p, lat);
    @(posedge clk) #1;
    drop(p);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    int l0, l1;
    rst = 1'b0;
    {req0, req1, lock0, lock1, wr0, wr1} = '0;
    {addr0, addr1, wdata0, wdata1} = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
    chk("rst_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
    chk("rst_strobe", 32'({mem_rd, mem_wr}), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    @(posedge clk) #1;
    rst = 1'b1;

    // single read, then owner drops req
    gq.push_back({1'b0, 1'b0, 8'h10, 16'h0000});
    rq.push_back({1'b0, 16'h1234});
    access(0, 1'b0, 8'h10, 16'h0000, l0);
    chk("read_lat", 32'(l0), 32'd2);
    @(negedge clk);
    chk("read_rvalid0", 32'(rvalid0), 32'd1);
    chk("read_rvalid1", 32'(rvalid1), 32'd0);
    chk("read_rdata", 32'(rdata), 32'h1234);
    chk("drop_strobe", 32'({gnt0, mem_rd, mem_wr}), 32'd0);

    // tie from IDLE with last = 0
`ifdef DMEM_ARB_RR_EN
    gq.push_back({1'b1, 1'b0, 8'h30, 16'h0000});
    gq.push_back({1'b0, 1'b0, 8'h10, 16'h0000});
    rq.push_back({1'b1, 16'h0A0A});
    rq.push_back({1'b0, 16'h1234});
`else
    gq.push_back({1'b0, 1'b0, 8'h10, 16'h0000});
    gq.push_back({1'b1, 1'b0, 8'h30, 16'h0000});
    rq.push_back({1'b0, 16'h1234});
    rq.push_back({1'b1, 16'h0A0A});
`endif
    fork
      access(0, 1'b0, 8'h10, 16'h0000, l0);
      access(1, 1'b0, 8'h30, 16'h0000, l1);
    join
`ifdef DMEM_ARB_RR_EN
    chk("tie_lat", 32'({l0[7:0], l1[7:0]}), 32'h0302);
`else
    chk("tie_lat", 32'({l0[7:0], l1[7:0]}), 32'h0203);
`endif

    // port 1 locked burst while port 0 waits
    repeat (4) gq.push_back({1'b1, 1'b0, 8'h30, 16'h0000});
    gq.push_back({1'b0, 1'b0, 8'h10, 16'h0000});
    repeat (4) rq.push_back({1'b1, 16'h0A0A});
    rq.push_back({1'b0, 16'h1234});
    fork
      begin
        int k;
        @(posedge clk) #1;
        drive(1, 1'b0, 8'h30, 16'h0000);
        lock1 = 1'b1;
        for (int i = 0; i < 4; i++) wait_gnt(1, k);
        @(posedge clk) #1;
        drop(1);
        lock1 = 1'b0;
      end
      begin
        int k;
        @(posedge clk) #1;
        wait_gnt(1, k);
        @(posedge clk) #1;
        drive(0, 1'b0, 8'h10, 16'h0000);
        wait_gnt(0, k);
        chk("burst_wait", 32'(k), 32'd4);
        @(posedge clk) #1;
        drop(0);
      end
    join

    // port 1 write, port 0 reads it back
    gq.push_back({1'b1, 1'b1, 8'h22, 16'hBEEF});
    access(1, 1'b1, 8'h22, 16'hBEEF, l1);
    chk("wr_lat", 32'(l1), 32'd2);
    gq.push_back({1'b0, 1'b0, 8'h22, 16'h0000});
    rq.push_back({1'b0, 16'hBEEF});
    access(0, 1'b0, 8'h22, 16'h0000, l0);
    chk("rd_after_wr_lat", 32'(l0), 32'd2);
    @(negedge clk);

    // reset right after a read grant
    gq.push_back({1'b0, 1'b0, 8'h10, 16'h0000});
    @(posedge clk) #1;
    drive(0, 1'b0, 8'h10, 16'h0000);
    wait_gnt(0, l0);
    @(posedge clk) #1;
    rst = 1'b0;
    drop(0);
    @(negedge clk);
    chk("midrst_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
    chk("midrst_gnt", 32'({gnt0, gnt1}), 32'd0);
    chk("midrst_mem", 32'({mem_rd, mem_wr, mem_addr, mem_wdata}),
        32'd0);
    @(posedge clk) #1;
    rst = 1'b1;

    // first tie after reset goes to port 0 in either mode
    gq.push_back({1'b0, 1'b0, 8'h10, 16'h0000});
    gq.push_back({1'b1, 1'b0, 8'h30, 16'h0000});
    rq.push_back({1'b0, 16'h1234});
    rq.push_back({1'b1, 16'h0A0A});
    fork
      access(0, 1'b0, 8'h10, 16'h0000, l0);
      access(1, 1'b0, 8'h30, 16'h0000, l1);
    join
    chk("tie_after_rst", 32'({l0[7:0], l1[7:0]}), 32'h0203);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("grants_drained", 32'(gq.size()), 32'd0);
    chk("reads_drained", 32'(rq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
